memory_unit: RTL

MEMORY_UNIT -- requirements
Module: memory_unit

---
 rtl/memory_unit.sv | 122 ++++++++++++
 1 files changed

// File: rtl/memory_unit.sv
// memory_unit: CPU RAM with power-up clear sweep and a program-load port.
// Ports:
//   clk, rst (async, active low)
//   bus_in            - value on the CPU bus
//   mar_read_from_bus - load MAR from bus_in[AWIDTH-1:0]
//   ram_read_from_bus - write bus_in into RAM[MAR]
//   ram_write_to_bus  - drive RAM[MAR] onto bus_out (asynchronous read)
//   bus_out, bus_out_en - read data / drive enable (data is 0 when not driving)
//   prog_mode, prog_valid, prog_addr, prog_data - loader interface
//   prog_ready, prog_count - loader handshake / saturating accepted-word count
//   cpu_hold          - CPU must stay halted (any state other than RUN)
//   conflict          - sticky: RAM read and write requested together in RUN
//   mar               - current MAR value
module memory_unit #(
    parameter int DEPTH  = 16,
    parameter int AWIDTH = 4,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] bus_in,
    input  logic              mar_read_from_bus,
    input  logic              ram_read_from_bus,
    input  logic              ram_write_to_bus,
    output logic [DWIDTH-1:0] bus_out,
    output logic              bus_out_en,
    input  logic              prog_mode,
    input  logic              prog_valid,
    input  logic [AWIDTH-1:0] prog_addr,
    input  logic [DWIDTH-1:0] prog_data,
    output logic              prog_ready,
    output logic [4:0]        prog_count,
    output logic              cpu_hold,
    output logic              conflict,
    output logic [AWIDTH-1:0] mar
);
    typedef enum logic [1:0] {S_CLEAR, S_RUN, S_PROG} state_t;

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] clr_addr_q, clr_addr_d;
    logic [AWIDTH-1:0] mar_q, mar_d;
    logic [4:0]        prog_count_q, prog_count_d;
    logic              conflict_q, conflict_d;
    logic              we;
    logic [AWIDTH-1:0] waddr;
    logic [DWIDTH-1:0] wdata;
    logic [DWIDTH-1:0] ram [DEPTH];

    always_comb begin
        state_d      = state_q;
        clr_addr_d   = clr_addr_q;
        mar_d        = mar_q;
        prog_count_d = prog_count_q;
        conflict_d   = conflict_q;
        we           = 1'b0;
        waddr        = mar_q;
        wdata        = bus_in;
        case (state_q)
            S_CLEAR: begin
                we         = 1'b1;
                waddr      = clr_addr_q;
                wdata      = '0;
                clr_addr_d = clr_addr_q + AWIDTH'(1);
                if (clr_addr_q == AWIDTH'(DEPTH - 1)) begin
                    clr_addr_d   = '0;
                    state_d      = prog_mode ? S_PROG : S_RUN;
                    prog_count_d = '0;
                end
            end
            S_RUN: begin
                if (mar_read_from_bus) mar_d = bus_in[AWIDTH-1:0];
                // A read-and-drive collision keeps the bus read and drops the write.
                we = ram_read_from_bus && !ram_write_to_bus;
                if (ram_read_from_bus && ram_write_to_bus) conflict_d = 1'b1;
                if (prog_mode) begin
                    state_d      = S_PROG;
                    prog_count_d = '0;
                end
            end
            S_PROG: begin
                we    = prog_valid;
                waddr = prog_addr;
                wdata = prog_data;
                if (prog_valid && prog_count_q != 5'd31) prog_count_d = prog_count_q + 5'd1;
                if (!prog_mode) begin
                    state_d = S_RUN;
                    mar_d   = '0;
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_CLEAR;
            clr_addr_q   <= '0;
            mar_q        <= '0;
            prog_count_q <= '0;
            conflict_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            mar_q        <= mar_d;
            prog_count_q <= prog_count_d;
            conflict_q   <= conflict_d;
        end
    end

    // No reset on the array; gating with rst drops a write interrupted by reset.
    always_ff @(posedge clk) begin
        if (rst && we) ram[waddr] <= wdata;
    end

    assign bus_out_en = (state_q == S_RUN) && ram_write_to_bus;
    assign bus_out    = bus_out_en ? ram[mar_q] : '0;
    assign prog_ready = state_q == S_PROG;
    assign cpu_hold   = state_q != S_RUN;
    assign prog_count = prog_count_q;
    assign conflict   = conflict_q;
    assign mar        = mar_q;
endmodule
